// File: rtl/rf_write_sched.sv
// rf_write_sched: arbitrates the single register-file write port between
// pipeline writeback (WB), a debug/loader channel (DBG) and an internal
// clear sequencer. Priority WB > CLEAR > DBG; one registered write per cycle.
module rf_write_sched #(
  parameter int unsigned WORD_LEN     = 32,
  parameter int unsigned ADDR_LEN     = 5,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_en,
  input  logic [ADDR_LEN-1:0] wb_dest,
  input  logic [WORD_LEN-1:0] wb_val,
  input  logic                dbg_valid,
  input  logic [ADDR_LEN-1:0] dbg_dest,
  input  logic [WORD_LEN-1:0] dbg_val,
  output logic                dbg_ready,
  input  logic                clr_start,
  output logic                clr_busy,
  output logic                clr_done,
  output logic                stall_out,
  output logic                rf_writeEn,
  output logic [ADDR_LEN-1:0] rf_dest,
  output logic [WORD_LEN-1:0] rf_writeVal
);

  localparam int unsigned CNT_W = 4;
  localparam logic [ADDR_LEN-1:0] LAST_IDX  = ADDR_LEN'(NUM_REGS - 1);
  localparam logic [ADDR_LEN-1:0] FIRST_IDX = ADDR_LEN'(1);
  localparam logic [CNT_W-1:0]    LIMIT     = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_LEN-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wen_q, wen_d;
  logic [ADDR_LEN-1:0] dest_q, dest_d;
  logic [WORD_LEN-1:0] val_q, val_d;
  logic                dbg_xfer;

  // DBG only wins an idle cycle that WB leaves free; held low in reset
  assign dbg_ready = dbg_valid & ~wb_en & (state_q == IDLE) & ~rst;
  assign dbg_xfer  = dbg_valid & dbg_ready;

  assign clr_busy    = (state_q == CLEAR);
  assign clr_done    = (state_q == DONE);
  assign stall_out   = (cnt_q == LIMIT) | (state_q == CLEAR);
  assign rf_writeEn  = wen_q;
  assign rf_dest     = dest_q;
  assign rf_writeVal = val_q;

  // Next-state: write-port mux, clear sequencer and DBG starve counter
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    dest_d  = dest_q;
    val_d   = val_q;

    // Write-port mux; register 0 is never written
    if (wb_en) begin
      wen_d  = (wb_dest != '0);
      dest_d = wb_dest;
      val_d  = wb_val;
    end else if (state_q == CLEAR) begin
      wen_d  = (idx_q != '0);
      dest_d = idx_q;
      val_d  = '0;
    end else if (dbg_xfer) begin
      wen_d  = (dbg_dest != '0);
      dest_d = dbg_dest;
      val_d  = dbg_val;
    end

    // Clear sequencer; a WB write in CLEAR holds the index
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          idx_d   = FIRST_IDX;
        end
      end
      CLEAR: begin
        if (!wb_en) begin
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + ADDR_LEN'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Starve counter: saturating count of denied idle DBG cycles
    if (!dbg_valid || dbg_xfer) begin
      cnt_d = '0;
    end else if ((state_q == IDLE) && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      dest_q  <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      dest_q  <= dest_d;
      val_q   <= val_d;
    end
  end

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed bench for rf_write_sched: expected rf_* writes are queued when a
// cycle is driven and popped after the following posedge.
module tb_rf_write_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_val;
  logic        dbg_valid;
  logic [4:0]  dbg_dest;
  logic [31:0] dbg_val;
  logic        dbg_ready;
  logic        clr_start;
  logic        clr_busy;
  logic        clr_done;
  logic        stall_out;
  logic        rf_writeEn;
  logic [4:0]  rf_dest;
  logic [31:0] rf_writeVal;

  typedef struct {
    logic        en;
    logic [4:0]  dest;
    logic [31:0] val;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_err    = 0;

  rf_write_sched dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
    .dbg_valid(dbg_valid), .dbg_dest(dbg_dest), .dbg_val(dbg_val),
    .dbg_ready(dbg_ready),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .stall_out(stall_out),
    .rf_writeEn(rf_writeEn), .rf_dest(rf_dest), .rf_writeVal(rf_writeVal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push_wr(input logic [4:0] d, input logic [31:0] v);
    wr_t e;
    e.en = 1'b1; e.dest = d; e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_none();
    wr_t e;
    e.en = 1'b0; e.dest = '0; e.val = '0;
    sb.push_back(e);
  endtask

  // Advance one posedge and compare rf_* with the oldest expectation
  task automatic step(input string tag);
    wr_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_wen"}, 32'(rf_writeEn), 32'(e.en));
      if (e.en) begin
        chk({tag, "_dest"}, 32'(rf_dest), 32'(e.dest));
        chk({tag, "_val"}, rf_writeVal, e.val);
      end
    end
  endtask

  task automatic idle_inputs();
    wb_en = 1'b0; wb_dest = '0; wb_val = '0;
    dbg_valid = 1'b0; dbg_dest = '0; dbg_val = '0;
    clr_start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wen"},   32'(rf_writeEn), 32'd0);
    chk({tag, "_dest"},  32'(rf_dest), 32'd0);
    chk({tag, "_val"},   rf_writeVal, 32'd0);
    chk({tag, "_busy"},  32'(clr_busy), 32'd0);
    chk({tag, "_done"},  32'(clr_done), 32'd0);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_rdy"},   32'(dbg_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    dbg_valid = 1'b1;
    dbg_dest  = 5'd3;

    // Reset held for three cycles; everything zero, DBG not accepted
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk_all_zero("reset");
    end

    // Release reset with a WB write
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    wb_en = 1'b1; wb_dest = 5'd5; wb_val = 32'hDEADBEEF;
    push_wr(5'd5, 32'hDEADBEEF);
    step("wb_first");

    // WB contends with DBG for six cycles; stall appears on the 5th denial
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      wb_en = 1'b1; wb_dest = 5'(10 + i); wb_val = 32'(32'h100 + i);
      dbg_valid = 1'b1; dbg_dest = 5'd7; dbg_val = 32'h1234;
      #1;
      chk("contend_rdy", 32'(dbg_ready), 32'd0);
      chk("contend_stall", 32'(stall_out), (i >= 4) ? 32'd1 : 32'd0);
      push_wr(5'(10 + i), 32'(32'h100 + i));
      step("contend_wb");
    end

    // WB drops: DBG accepted, stall still up this cycle
    @(negedge clk);
    wb_en = 1'b0;
    #1;
    chk("dbg_go_rdy", 32'(dbg_ready), 32'd1);
    chk("dbg_go_stall", 32'(stall_out), 32'd1);
    push_wr(5'd7, 32'h1234);
    step("dbg_write");
    @(negedge clk);
    dbg_valid = 1'b0;
    #1;
    chk("stall_fall", 32'(stall_out), 32'd0);
    push_none();
    step("dbg_after");

    // Register 0 suppression: WB then DBG
    @(negedge clk);
    wb_en = 1'b1; wb_dest = 5'd0; wb_val = 32'hFFFFFFFF;
    push_none();
    step("wb_r0");
    @(negedge clk);
    wb_en = 1'b0;
    dbg_valid = 1'b1; dbg_dest = 5'd0; dbg_val = 32'hCAFE;
    #1;
    chk("dbg_r0_rdy", 32'(dbg_ready), 32'd1);
    push_none();
    step("dbg_r0");

    // Full clear with DBG pending throughout
    @(negedge clk);
    dbg_valid = 1'b0;
    clr_start = 1'b1;
    push_none();
    step("clr_start");
    @(negedge clk);
    clr_start = 1'b0;
    dbg_valid = 1'b1; dbg_dest = 5'd12; dbg_val = 32'h55;
    for (int k = 1; k < 32; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      chk("clr_busy", 32'(clr_busy), 32'd1);
      chk("clr_stall", 32'(stall_out), 32'd1);
      chk("clr_done_early", 32'(clr_done), 32'd0);
      chk("clr_rdy", 32'(dbg_ready), 32'd0);
      push_wr(5'(k), 32'd0);
      step("clr_wr");
    end
    @(negedge clk);
    #1;
    chk("clr_done", 32'(clr_done), 32'd1);
    chk("done_busy", 32'(clr_busy), 32'd0);
    chk("done_rdy", 32'(dbg_ready), 32'd0);
    push_none();
    step("clr_done_cyc");
    @(negedge clk);
    #1;
    chk("idle_done", 32'(clr_done), 32'd0);
    chk("idle_rdy", 32'(dbg_ready), 32'd1);
    push_wr(5'd12, 32'h55);
    step("idle_dbg");

    // Clear started together with a DBG write; WB interrupts at index 4
    @(negedge clk);
    clr_start = 1'b1;
    dbg_valid = 1'b1; dbg_dest = 5'd20; dbg_val = 32'h77;
    #1;
    chk("start_dbg_rdy", 32'(dbg_ready), 32'd1);
    push_wr(5'd20, 32'h77);
    step("start_dbg");
    @(negedge clk);
    clr_start = 1'b0;
    dbg_valid = 1'b0;
    for (int k = 1; k < 32; k++) begin
      if (k == 4) begin
        wb_en = 1'b1; wb_dest = 5'd9; wb_val = 32'hA5;
        push_wr(5'd9, 32'hA5);
        step("int_wb");
        @(negedge clk);
        wb_en = 1'b0;
      end
      #1;
      chk("int_done_early", 32'(clr_done), 32'd0);
      push_wr(5'(k), 32'd0);
      step("int_clr");
      @(negedge clk);
    end
    #1;
    chk("int_done", 32'(clr_done), 32'd1);
    push_none();
    step("int_done_cyc");

    // Clear aborted by reset at index 10
    @(negedge clk);
    clr_start = 1'b1;
    push_none();
    step("abort_start");
    @(negedge clk);
    clr_start = 1'b0;
    for (int k = 1; k < 10; k++) begin
      push_wr(5'(k), 32'd0);
      step("abort_clr");
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk_all_zero("abort_rst");
    @(posedge clk);
    #1;
    chk_all_zero("abort_hold");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_done", 32'(clr_done), 32'd0);
      chk("post_busy", 32'(clr_busy), 32'd0);
      push_none();
      step("post_idle");
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_sched.md
Name: rf_write_sched

Overview:
- Scheduler for the single register-file write port (writeEn/dest/writeVal).
- Three write sources share the port:
  - pipeline writeback (WB);
  - a debug/loader write channel (DBG) using a valid/ready handshake;
  - an internal clear sequencer that zeroes registers 1..NUM_REGS-1.
- Sits between the WB stage and the register file.
- Also drives a stall request to the pipeline to prevent DBG starvation and to freeze the core during a clear.

Parameters:
- WORD_LEN, 32, data width of register values.
- ADDR_LEN, 5, register address width.
- NUM_REGS, 32, number of architectural registers.
- STARVE_LIMIT, 4, consecutive denied DBG cycles before stall_out is raised (1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- wb_en  in  1  WB write request.
- wb_dest  in  ADDR_LEN  WB destination register.
- wb_val  in  WORD_LEN  WB write data.
- dbg_valid  in  1  DBG write request valid.
- dbg_dest  in  ADDR_LEN  DBG destination register.
- dbg_val  in  WORD_LEN  DBG write data.
- dbg_ready  out  1  DBG accepted this cycle (combinational).
- clr_start  in  1  start a clear sequence (sampled only in IDLE).
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- stall_out  out  1  request that the pipeline freeze (WB must drop wb_en).
- rf_writeEn  out  1  register-file write enable (registered).
- rf_dest  out  ADDR_LEN  register-file write address (registered).
- rf_writeVal  out  WORD_LEN  register-file write data (registered).

Behaviour:
- Reset (asynchronous, any time, including mid-clear):
  - FSM goes to IDLE; starve counter = 0.
  - rf_writeEn = 0, rf_dest = 0, rf_writeVal = 0.
  - clr_busy = 0, clr_done = 0, stall_out = 0, dbg_ready = 0.
- Latency: the winning source in cycle N appears on rf_* after posedge N+1. The register file samples it on the following negedge. WB forwarding logic accounts for this one cycle.
- Priority each cycle: WB > CLEAR > DBG. Exactly one write or none per cycle.
- WB: if wb_en = 1, always granted; never back-pressured.
- DBG:
  - dbg_ready = dbg_valid & ~wb_en & (state == IDLE).
  - A transfer occurs when dbg_valid & dbg_ready.
  - dbg_dest/dbg_val must hold stable while dbg_valid = 1 and dbg_ready = 0.
- Writes to register 0 from any source produce rf_writeEn = 0. For DBG, this still completes the handshake.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle dbg_valid = 1 and dbg_ready = 0 in IDLE.
  - Clears on a DBG transfer or when dbg_valid = 0.
- stall_out = (counter == STARVE_LIMIT) | (state == CLEAR).
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start: index loaded with 1; clr_busy = 1 from the next cycle.
  - CLEAR: each cycle without wb_en, write 0 to register index, then index++.
  - CLEAR: a cycle with wb_en writes WB instead and holds the index. This covers WB still in flight at stall onset.
  - CLEAR -> DONE after the write of index NUM_REGS-1.
  - DONE: clr_done = 1 for exactly one cycle, clr_busy = 0, then -> IDLE.
  - clr_start outside IDLE is ignored.
  - DBG is never granted in CLEAR or DONE.
- Simultaneous wb_en and dbg_valid in IDLE: WB written, DBG held, counter increments.
- Simultaneous clr_start and dbg_valid in IDLE (no wb_en): the DBG transfer is granted this cycle, then the FSM enters CLEAR.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 3 cycles, release; wb_en = 1, wb_dest = 5, wb_val = 0xDEADBEEF.
  - Required: rf_writeEn = 1, rf_dest = 5, rf_writeVal = 0xDEADBEEF exactly one posedge later; all outputs 0 during reset.
- WB vs DBG contention:
  - Stimulus: dbg_valid = 1 (dest 7, val 0x1234) while wb_en is held 1 for 6 cycles.
  - Required: dbg_ready = 0 throughout; stall_out rises in the 5th denied cycle (counter reaches 4).
  - Stimulus: wb_en drops.
  - Required: dbg_ready = 1; next cycle rf_dest = 7, rf_writeVal = 0x1234; stall_out falls.
- Register-0 suppression:
  - Stimulus: wb_en with dest 0, val 0xFFFFFFFF.
  - Required: rf_writeEn = 0.
  - Stimulus: DBG write to dest 0.
  - Required: handshake completes, rf_writeEn = 0.
- Full clear:
  - Stimulus: clr_start pulse.
  - Required: clr_busy and stall_out high; rf_dest steps 1..31 with val 0 on 31 consecutive cycles; clr_done pulses once; FSM returns to IDLE.
- Clear interrupted:
  - Stimulus: wb_en (dest 9, val 0xA5) at clear index 4.
  - Required: rf shows dest 9 / 0xA5 that cycle, then the clear resumes at 4; clr_done arrives one cycle later than in the full-clear case.
  - Stimulus: rst asserted at index 10.
  - Required: outputs zero immediately, FSM in IDLE, no clr_done.
